// File: rtl/ddr2_imem_loader.sv
// Copy engine: reads 128-bit lines from DDR2 and writes them as four 32-bit
// words into instruction memory, with a per-line read timeout.
module ddr2_imem_loader #(
    parameter int ADDR_STEP = 8,
    parameter int LEN_W     = 16,
    parameter int TIMEOUT   = 1000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [23:0]      src_addr,
    input  logic [11:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
    output logic             ddr2_re,
    output logic [23:0]      ddr2_addr,
    input  logic [127:0]     ddr2_rdata,
    input  logic             ddr2_rend,
    output logic             imem_we,
    output logic [11:0]      imem_a,
    output logic [31:0]      imem_d,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] T_LIMIT = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, WRITE, RELEASE} state_t;

    state_t             state_r, state_s;
    logic [23:0]        line_addr_r, line_addr_s;
    logic [11:0]        dst_r, dst_s;
    logic [LEN_W-1:0]   left_r, left_s;
    logic [TW-1:0]      tcnt_r, tcnt_s;
    logic [1:0]         k_r, k_s;
    logic [1:0]         k_inc_s;
    logic [127:0]       line_r, line_s;
    logic               ddr2_re_s, imem_we_s, busy_s, done_s, err_s;
    logic [23:0]        ddr2_addr_s;
    logic [11:0]        imem_a_s;
    logic [31:0]        imem_d_s;

    function automatic logic [31:0] word_sel(input logic [127:0] l, input logic [1:0] idx);
        logic [31:0] w;
        case (idx)
            2'd0:    w = l[31:0];
            2'd1:    w = l[63:32];
            2'd2:    w = l[95:64];
            2'd3:    w = l[127:96];
            default: w = 32'd0;
        endcase
        return w;
    endfunction

    // Next-state and next-output computation; every register holds by default.
    always_comb begin
        state_s     = state_r;
        line_addr_s = line_addr_r;
        dst_s       = dst_r;
        left_s      = left_r;
        tcnt_s      = tcnt_r;
        k_s         = k_r;
        line_s      = line_r;
        ddr2_re_s   = ddr2_re;
        ddr2_addr_s = ddr2_addr;
        imem_we_s   = imem_we;
        imem_a_s    = imem_a;
        imem_d_s    = imem_d;
        busy_s      = busy;
        done_s      = done;
        err_s       = err;
        k_inc_s     = k_r + 2'd1;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (len != {LEN_W{1'b0}}) begin
                        line_addr_s = src_addr;
                        dst_s       = dst_addr;
                        left_s      = len;
                        done_s      = 1'b0;
                        err_s       = 1'b0;
                        busy_s      = 1'b1;
                        ddr2_re_s   = 1'b1;
                        ddr2_addr_s = src_addr;
                        tcnt_s      = {TW{1'b0}};
                        state_s     = REQ;
                    end else begin
                        err_s  = 1'b0;
                        done_s = 1'b1;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            REQ: begin
                tcnt_s  = tcnt_r + TW'(1);
                state_s = WAIT;
            end
            WAIT: begin
                if (ddr2_rend) begin
                    line_s    = ddr2_rdata;
                    ddr2_re_s = 1'b0;
                    k_s       = 2'd0;
                    imem_we_s = 1'b1;
                    imem_a_s  = dst_r;
                    imem_d_s  = ddr2_rdata[31:0];
                    state_s   = WRITE;
                end else if (tcnt_r == T_LIMIT) begin
                    ddr2_re_s = 1'b0;
                    err_s     = 1'b1;
                    busy_s    = 1'b0;
                    state_s   = IDLE;
                end else begin
                    tcnt_s = tcnt_r + TW'(1);
                end
            end
            WRITE: begin
                if (k_r == 2'd3) begin
                    imem_we_s = 1'b0;
                    dst_s     = dst_r + 12'd4;
                    left_s    = left_r - LEN_W'(1);
                    tcnt_s    = {TW{1'b0}};
                    state_s   = RELEASE;
                end else begin
                    k_s       = k_inc_s;
                    imem_we_s = 1'b1;
                    imem_a_s  = dst_r + {10'd0, k_inc_s};
                    imem_d_s  = word_sel(line_r, k_inc_s);
                end
            end
            RELEASE: begin
                // A completion still high here belongs to the line just written.
                if (!ddr2_rend) begin
                    if (left_r != {LEN_W{1'b0}}) begin
                        line_addr_s = line_addr_r + 24'(ADDR_STEP);
                        ddr2_addr_s = line_addr_r + 24'(ADDR_STEP);
                        ddr2_re_s   = 1'b1;
                        tcnt_s      = {TW{1'b0}};
                        state_s     = REQ;
                    end else begin
                        done_s  = 1'b1;
                        busy_s  = 1'b0;
                        state_s = IDLE;
                    end
                end else if (tcnt_r == T_LIMIT) begin
                    err_s   = 1'b1;
                    busy_s  = 1'b0;
                    state_s = IDLE;
                end else begin
                    tcnt_s = tcnt_r + TW'(1);
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            line_addr_r <= 24'd0;
            dst_r       <= 12'd0;
            left_r      <= {LEN_W{1'b0}};
            tcnt_r      <= {TW{1'b0}};
            k_r         <= 2'd0;
            line_r      <= 128'd0;
            ddr2_re     <= 1'b0;
            ddr2_addr   <= 24'd0;
            imem_we     <= 1'b0;
            imem_a      <= 12'd0;
            imem_d      <= 32'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state_r     <= state_s;
            line_addr_r <= line_addr_s;
            dst_r       <= dst_s;
            left_r      <= left_s;
            tcnt_r      <= tcnt_s;
            k_r         <= k_s;
            line_r      <= line_s;
            ddr2_re     <= ddr2_re_s;
            ddr2_addr   <= ddr2_addr_s;
            imem_we     <= imem_we_s;
            imem_a      <= imem_a_s;
            imem_d      <= imem_d_s;
            busy        <= busy_s;
            done        <= done_s;
            err         <= err_s;
        end
    end

endmodule

// File: tb/tb_ddr2_imem_loader.sv
// Directed bench for ddr2_imem_loader with a behavioural DDR2 responder and IMEM model.
module tb_ddr2_imem_loader;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [23:0]  src_addr;
    logic [11:0]  dst_addr;
    logic [15:0]  len;
    logic         ddr2_re;
    logic [23:0]  ddr2_addr;
    logic [127:0] ddr2_rdata = 128'd0;
    logic         ddr2_rend  = 1'b0;
    logic         imem_we;
    logic [11:0]  imem_a;
    logic [31:0]  imem_d;
    logic         busy, done, err;

    int checks = 0;
    int errors = 0;

    logic [31:0] imem [0:4095];
    logic [23:0] req_q [$];
    logic [11:0] wr_q [$];
    int          re_count = 0;
    bit          prev_re = 1'b0;
    int          lat = 20;
    int          dcnt = 0;
    bit          never = 1'b0;
    bit          stuck = 1'b0;
    bit          use_fixed = 1'b1;

    localparam logic [127:0] FIXED = 128'h44444444_33333333_22222222_11111111;

    ddr2_imem_loader #(.ADDR_STEP(8), .LEN_W(16), .TIMEOUT(64)) dut (
        .clk(clk), .reset(reset), .start(start), .src_addr(src_addr),
        .dst_addr(dst_addr), .len(len), .ddr2_re(ddr2_re), .ddr2_addr(ddr2_addr),
        .ddr2_rdata(ddr2_rdata), .ddr2_rend(ddr2_rend), .imem_we(imem_we),
        .imem_a(imem_a), .imem_d(imem_d), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input logic [23:0] a, input int i);
        return {a, 8'hA0 + 8'(i)};
    endfunction

    function automatic logic [127:0] line_for(input logic [23:0] a);
        logic [127:0] l;
        for (int i = 0; i < 4; i++) l[32*i +: 32] = pat(a, i);
        return l;
    endfunction

    // DDR2 responder: completes after lat cycles of request, releases when request drops
    always @(negedge clk) begin
        if (reset) begin
            dcnt = 0;
            ddr2_rend = 1'b0;
        end else if (ddr2_re) begin
            if (!never) begin
                dcnt = dcnt + 1;
                if (dcnt >= lat) begin
                    ddr2_rend  = 1'b1;
                    ddr2_rdata = use_fixed ? FIXED : line_for(ddr2_addr);
                end
            end
        end else begin
            dcnt = 0;
            if (!stuck) ddr2_rend = 1'b0;
        end
    end

    // IMEM capture and request logging
    always @(negedge clk) begin
        if (imem_we) begin
            imem[imem_a] = imem_d;
            wr_q.push_back(imem_a);
        end
        if (ddr2_re && !prev_re) begin
            re_count = re_count + 1;
            req_q.push_back(ddr2_addr);
        end
        prev_re = ddr2_re;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        re_count = 0;
        req_q.delete();
        wr_q.delete();
    endtask

    task automatic go(input logic [23:0] s, input logic [11:0] d, input logic [15:0] n);
        @(negedge clk);
        src_addr = s;
        dst_addr = d;
        len      = n;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int i;
        i = 0;
        while (busy && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk(tag, busy, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        bit ok;
        logic [11:0] exp_a [8];
        reset = 1'b1; start = 1'b0; src_addr = 24'd0; dst_addr = 12'd0; len = 16'd0;
        for (int i = 0; i < 4096; i++) imem[i] = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_flags", {ddr2_re, imem_we, busy, done, err}, 5'd0);
        chk("rst_buses", {ddr2_addr, imem_a, imem_d}, 68'd0);
        reset = 1'b0;

        // single line, fixed data
        clear_logs(); use_fixed = 1'b1; lat = 20;
        go(24'h000010, 12'h000, 16'd1);
        wait_idle("t1_wait", 200);
        chk("t1_w0", imem[0], 32'h11111111);
        chk("t1_w1", imem[1], 32'h22222222);
        chk("t1_w2", imem[2], 32'h33333333);
        chk("t1_w3", imem[3], 32'h44444444);
        chk("t1_flags", {done, busy, err}, 3'b100);
        chk("t1_re_count", re_count, 1);
        chk("t1_nreq", req_q.size(), 1);
        if (req_q.size() > 0) chk("t1_addr", req_q[0], 24'h000010);
        chk("t1_nwr", wr_q.size(), 4);

        // three lines
        clear_logs(); use_fixed = 1'b0;
        go(24'h000000, 12'h010, 16'd3);
        wait_idle("t2_wait", 600);
        chk("t2_flags", {done, busy, err}, 3'b100);
        chk("t2_nreq", req_q.size(), 3);
        for (int l = 0; l < 3 && l < req_q.size(); l++)
            chk($sformatf("t2_req%0d", l), req_q[l], 24'(8 * l));
        chk("t2_nwr", wr_q.size(), 12);
        ok = 1'b1;
        for (int j = 0; j < wr_q.size(); j++)
            if (wr_q[j] !== 12'(16 + j)) ok = 1'b0;
        chk("t2_order", ok, 1'b1);
        for (int l = 0; l < 3; l++)
            for (int i = 0; i < 4; i++)
                chk($sformatf("t2_d%0d_%0d", l, i), imem[16 + 4 * l + i], pat(24'(8 * l), i));

        // address wrap on both sides
        clear_logs();
        go(24'hFFFFF8, 12'hFFC, 16'd2);
        wait_idle("t3_wait", 400);
        chk("t3_nreq", req_q.size(), 2);
        if (req_q.size() == 2) chk("t3_reqs", {req_q[0], req_q[1]}, {24'hFFFFF8, 24'h000000});
        exp_a = '{12'hFFC, 12'hFFD, 12'hFFE, 12'hFFF, 12'h000, 12'h001, 12'h002, 12'h003};
        chk("t3_nwr", wr_q.size(), 8);
        ok = 1'b1;
        for (int j = 0; j < 8 && j < wr_q.size(); j++)
            if (wr_q[j] !== exp_a[j]) ok = 1'b0;
        chk("t3_order", ok, 1'b1);
        chk("t3_hi", imem[12'hFFF], pat(24'hFFFFF8, 3));
        chk("t3_lo0", imem[0], pat(24'h000000, 0));
        chk("t3_lo3", imem[3], pat(24'h000000, 3));

        // read timeout
        clear_logs(); never = 1'b1;
        go(24'h000100, 12'h300, 16'd2);
        cyc = 0;
        while (!err && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("t4_cycles", cyc, 64);
        chk("t4_flags", {err, busy, ddr2_re, done}, 4'b1000);
        repeat (5) @(negedge clk);
        chk("t4_nwr", wr_q.size(), 0);
        chk("t4_re_count", re_count, 1);
        never = 1'b0; clear_logs();
        go(24'h000100, 12'h300, 16'd1);
        chk("t4_err_clr", err, 1'b0);
        wait_idle("t4_wait", 200);
        chk("t4_after", {done, err}, 2'b10);

        // completion held high after the first line, then released
        clear_logs(); stuck = 1'b1;
        go(24'h000200, 12'h040, 16'd2);
        cyc = 0;
        while (!(imem_we && imem_a == 12'h043) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        repeat (30) @(negedge clk);
        chk("t5_hold", {busy, ddr2_re, err}, 3'b100);
        chk("t5_one_req", re_count, 1);
        stuck = 1'b0;
        wait_idle("t5_wait", 200);
        chk("t5_re_count", re_count, 2);
        chk("t5_flags", {done, err}, 2'b10);
        chk("t5_nwr", wr_q.size(), 8);

        // completion never released: RELEASE times out
        clear_logs(); stuck = 1'b1;
        go(24'h000200, 12'h040, 16'd2);
        wait_idle("t5b_wait", 300);
        chk("t5b_flags", {err, done}, 2'b10);
        chk("t5b_re_count", re_count, 1);
        chk("t5b_nwr", wr_q.size(), 4);
        stuck = 1'b0;
        repeat (2) @(negedge clk);

        // reset during the third word write
        clear_logs(); use_fixed = 1'b1;
        go(24'h000300, 12'h080, 16'd1);
        cyc = 0;
        while (!(imem_we && imem_a == 12'h081) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        @(posedge clk);
        #1 reset = 1'b1;
        #1 chk("t6_async", {ddr2_re, imem_we, busy, done, err, imem_a, imem_d, ddr2_addr}, 73'd0);
        @(negedge clk);
        reset = 1'b0;
        chk("t6_w0", imem[12'h080], 32'h11111111);
        chk("t6_w1", imem[12'h081], 32'h22222222);
        chk("t6_w2", imem[12'h082], 32'h00000000);
        chk("t6_nwr", wr_q.size(), 2);

        // zero length
        clear_logs();
        go(24'h000600, 12'h600, 16'd0);
        chk("t8_flags", {done, busy, err}, 3'b100);
        repeat (5) @(negedge clk);
        chk("t8_idle", {re_count, wr_q.size()}, 64'd0);

        // start while busy is ignored
        clear_logs(); use_fixed = 1'b0;
        go(24'h000400, 12'h100, 16'd1);
        repeat (3) @(negedge clk);
        go(24'h000500, 12'h200, 16'd3);
        wait_idle("t7_wait", 300);
        chk("t7_re_count", re_count, 1);
        if (req_q.size() > 0) chk("t7_addr", req_q[0], 24'h000400);
        chk("t7_nwr", wr_q.size(), 4);
        chk("t7_data", imem[12'h100], pat(24'h000400, 0));
        chk("t7_untouched", imem[12'h200], 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
